chimera_cluster_ctrl_apb: RTL and testbench
===========================================

Name: chimera_cluster_ctrl_apb

Overview:
APB completer for the top-level configuration window at 0x3000_1000–0x3000_1FFF.
- Owns per-cluster clock enables and per-cluster soft resets, and exposes their status.
- Answers the APB requests routed from the SoC register demux.
- Drives the cluster clock-gate enables and cluster reset lines.
- Inserts wait states on clock-enable changes so the gates settle before the write completes.

Parameters:
NumClusters, 5, number of clusters controlled (1..32)
SettleCycles, 4, wait states added to a CLK_EN write that changes any enable bit (>=1)
RstCycles, 16, cycles a cluster reset stays asserted after a SOFT_RST request (>=1)
ChimeraId, 32'hC41E_0001, constant returned by the ID register

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
paddr_i  in  32  APB address; only [11:0] decoded
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
pprot_i  in  3  APB protection; ignored
pready_o  out  1  APB ready
prdata_o  out  32  APB read data
pslverr_o  out  1  APB error
cluster_clk_en_o  out  NumClusters  clock-gate enable per cluster
cluster_rst_o  out  NumClusters  active-high cluster reset per cluster

Behaviour:
Synchronous active-high reset.
- Reset values: cluster_clk_en_o=0; cluster_rst_o=all ones; all reset counters loaded with RstCycles.
- Clusters therefore come out of reset RstCycles cycles after rst_i deasserts.
- FSM returns to IDLE. pready_o=0, prdata_o=0, pslverr_o=0.

Register map (offset = paddr_i[11:0]):
- 0x000 CLK_EN: RW, bits [NumClusters-1:0]; upper bits read 0.
- 0x004 SOFT_RST: WO. Writing 1 to bit i starts reset of cluster i. Reads return 0.
- 0x008 STATUS: RO. [NumClusters-1:0] = cluster_rst_o; bit 31 = settle in progress (always 0 when observable).
- 0x00C ID: RO, returns ChimeraId.
- Writes to STATUS or ID: no effect, pslverr_o=1.
- Any other offset, or paddr_i[1:0]!=0: pslverr_o=1, prdata_o=0, no state change.
- Byte strobes apply to CLK_EN and SOFT_RST. A lane with pstrb_i=0 leaves that byte unchanged (CLK_EN) or requests nothing (SOFT_RST).

FSM states:
- IDLE
  - psel_i & penable_i, CLK_EN write whose masked new value differs from current → SETTLE. Enables update that same cycle; counter loaded with SettleCycles-1; pready_o=0.
  - Any other access phase → completes combinationally in the same cycle: pready_o=1, prdata_o/pslverr_o valid. Stay IDLE.
  - Setup phase (psel_i & !penable_i) → no action, pready_o=0.
- SETTLE
  - pready_o=0 while counter>0; counter decrements each cycle.
  - At counter==0: pready_o=1, then → IDLE.
  - A CLK_EN write that changes enables completes after exactly SettleCycles wait states.
  - A CLK_EN write with unchanged value completes with zero wait states.
- Requester must hold APB signals stable while pready_o=0. If psel_i drops mid-SETTLE (protocol violation), finish counting, then return to IDLE without asserting pready_o.

Reset counters (one per cluster):
- A SOFT_RST write bit i → cluster_rst_o[i]=1 from the next cycle; counter[i] loaded with RstCycles-1.
- cluster_rst_o[i] clears the cycle after counter[i] reaches 0, i.e. high for exactly RstCycles cycles.
- Re-request while active restarts the count. Multiple bits can be requested in one write.
- Soft reset does not touch CLK_EN.
- rst_i mid-transaction or mid-SETTLE: all state returns to reset values next cycle; the in-flight APB transfer is dropped.

Decomposition:
- chimera_pkg holds:
  - typedefs apb_req_t/apb_resp_t (addr_t 32 bit, data_t 32 bit, strb_t 4 bit)
  - the TopLevel region start/end constants
  - localparams for register offsets (CLK_EN, SOFT_RST, STATUS, ID)
- Sub-module chimera_rst_pulse: a single down-counter reset stretcher (start, busy). Instantiate it NumClusters times.

Test Plan:
- Reset release, no APB traffic → cluster_rst_o=5'b11111 for 16 cycles, then 0; cluster_clk_en_o=0; read ID → 0xC41E_0001 with 0 wait states.
- Write CLK_EN=0x15 → cluster_clk_en_o=5'b10101 in the access cycle; pready_o high after exactly 4 wait states; rewrite 0x15 → 0 wait states.
- Write CLK_EN=0xFF with pstrb_i=4'b0000 → no change, 0 wait states; readback 0x15.
- Write SOFT_RST=0x02; at cycle 10 write 0x02 again → cluster_rst_o[1] high for 10+16 cycles total; STATUS read mid-way → 0x0000_0002.
- Read offset 0x010, write STATUS, access paddr 0x3000_1002 → pslverr_o=1, prdata_o=0, no state change.
- Assert rst_i during the SETTLE of CLK_EN=0x1F → next cycle cluster_clk_en_o=0, pready_o=0, all cluster_rst_o=1.

Source files
------------

// File: rtl/chimera_pkg.sv
// rtl/chimera_pkg.sv - shared APB types, register map and window constants for the cluster controller
package chimera_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  typedef struct packed {
    logic       psel;
    logic       penable;
    logic       pwrite;
    addr_t      paddr;
    data_t      pwdata;
    strb_t      pstrb;
    logic [2:0] pprot;
  } apb_req_t;

  typedef struct packed {
    logic  pready;
    data_t prdata;
    logic  pslverr;
  } apb_resp_t;

  typedef enum logic [0:0] {
    StIdle,
    StSettle
  } ctrl_state_e;

  localparam addr_t TopLevelStart = 32'h3000_1000;
  localparam addr_t TopLevelEnd   = 32'h3000_1FFF;

  // Only the offset inside the window is decoded; the demux has already matched the base.
  localparam int unsigned RegOffsetBits = $clog2(TopLevelEnd - TopLevelStart + 1);
  typedef logic [RegOffsetBits-1:0] reg_off_t;

  localparam reg_off_t RegClkEn   = 'h000;
  localparam reg_off_t RegSoftRst = 'h004;
  localparam reg_off_t RegStatus  = 'h008;
  localparam reg_off_t RegId      = 'h00C;

  function automatic data_t strb_to_mask(strb_t strb);
    data_t mask;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/chimera_cluster_ctrl_apb_if.sv
// rtl/chimera_cluster_ctrl_apb_if.sv - APB completer bundle between the SoC register demux and the cluster controller
interface chimera_cluster_ctrl_apb_if;
  import chimera_pkg::*;

  logic       psel_i;
  logic       penable_i;
  logic       pwrite_i;
  addr_t      paddr_i;
  data_t      pwdata_i;
  strb_t      pstrb_i;
  logic [2:0] pprot_i;
  logic       pready_o;
  data_t      prdata_o;
  logic       pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, pprot_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, pprot_i,
    output pready_o, prdata_o, pslverr_o
  );

endinterface

// File: rtl/chimera_rst_pulse.sv
// rtl/chimera_rst_pulse.sv - reset stretcher: busy for exactly Cycles cycles after start, restartable
module chimera_rst_pulse #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic busy_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_busy;

  // Power-on loads one extra count so the cluster releases Cycles cycles after rst_i drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= CntW'(Cycles);
      r_busy <= 1'b1;
    end else if (start_i) begin
      r_cnt  <= CntW'(Cycles - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CntW'(1);
      end
    end
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/chimera_cluster_ctrl_apb.sv
// rtl/chimera_cluster_ctrl_apb.sv - APB completer owning per-cluster clock enables and soft resets
module chimera_cluster_ctrl_apb
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters  = 5,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned RstCycles    = 16,
  parameter data_t       ChimeraId    = 32'hC41E_0001
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  chimera_cluster_ctrl_apb_if.slave  apb,
  output logic [NumClusters-1:0]     cluster_clk_en_o,
  output logic [NumClusters-1:0]     cluster_rst_o
);

  localparam int unsigned SettleW = $clog2(SettleCycles + 1);
  typedef logic [SettleW-1:0] settle_cnt_t;

  apb_req_t               w_req;
  apb_resp_t              w_resp;
  ctrl_state_e            r_state, w_state_nxt;
  settle_cnt_t            r_settle_cnt, w_settle_nxt;
  logic [NumClusters-1:0] r_clk_en, w_clk_en_nxt, w_clk_en_new, w_start;
  reg_off_t               w_offset;
  data_t                  w_mask, w_wr_masked, w_rst_req, w_clk_en_ext, w_status;
  logic                   w_access;
  logic                   w_unused;

  assign w_req = '{psel: apb.psel_i, penable: apb.penable_i, pwrite: apb.pwrite_i,
                   paddr: apb.paddr_i, pwdata: apb.pwdata_i, pstrb: apb.pstrb_i,
                   pprot: apb.pprot_i};

  assign w_offset     = w_req.paddr[RegOffsetBits-1:0];
  assign w_access     = w_req.psel & w_req.penable;
  assign w_mask       = strb_to_mask(w_req.pstrb);
  assign w_clk_en_ext = data_t'(r_clk_en);
  assign w_wr_masked  = (w_clk_en_ext & ~w_mask) | (w_req.pwdata & w_mask);
  assign w_rst_req    = w_req.pwdata & w_mask;
  assign w_clk_en_new = w_wr_masked[NumClusters-1:0];
  assign w_status     = data_t'(cluster_rst_o) | {r_state == StSettle, 31'b0};
  assign w_unused     = ^{w_req.paddr, w_req.pprot, w_wr_masked, w_rst_req};

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_clk_en_nxt = r_clk_en;
    w_start      = '0;
    w_resp       = '0;
    case (r_state)
      StIdle: begin
        if (w_access) begin
          // Changing any gate enable stalls the write so the gates settle before completion.
          if (w_req.pwrite && (w_offset == RegClkEn) && (w_clk_en_new != r_clk_en)) begin
            w_clk_en_nxt = w_clk_en_new;
            w_settle_nxt = settle_cnt_t'(SettleCycles - 1);
            w_state_nxt  = StSettle;
          end else begin
            w_resp.pready = 1'b1;
            case (w_offset)
              RegClkEn: begin
                if (!w_req.pwrite) w_resp.prdata = w_clk_en_ext;
              end
              RegSoftRst: begin
                if (w_req.pwrite) w_start = w_rst_req[NumClusters-1:0];
              end
              RegStatus: begin
                if (w_req.pwrite) w_resp.pslverr = 1'b1;
                else              w_resp.prdata  = w_status;
              end
              RegId: begin
                if (w_req.pwrite) w_resp.pslverr = 1'b1;
                else              w_resp.prdata  = ChimeraId;
              end
              default: w_resp.pslverr = 1'b1;
            endcase
          end
        end
      end
      StSettle: begin
        if (r_settle_cnt == '0) begin
          // A requester that abandoned the transfer gets no ready pulse.
          w_resp.pready = w_access;
          w_state_nxt   = StIdle;
        end else begin
          w_settle_nxt = r_settle_cnt - settle_cnt_t'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_settle_cnt <= '0;
      r_clk_en     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_clk_en     <= w_clk_en_nxt;
    end
  end

  for (genvar g = 0; g < NumClusters; g++) begin : g_rst
    chimera_rst_pulse #(
      .Cycles(RstCycles)
    ) u_rst_pulse (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .start_i(w_start[g]),
      .busy_o (cluster_rst_o[g])
    );
  end

  assign cluster_clk_en_o = r_clk_en;
  assign apb.pready_o     = w_resp.pready & ~rst_i;
  assign apb.prdata_o     = rst_i ? '0 : w_resp.prdata;
  assign apb.pslverr_o    = w_resp.pslverr & ~rst_i;

endmodule

// File: tb/tb_chimera_cluster_ctrl_apb.sv
// tb/tb_chimera_cluster_ctrl_apb.sv - self-checking bench for the cluster controller APB completer
module tb_chimera_cluster_ctrl_apb;

  localparam int          NC   = 5;
  localparam int          SC   = 4;
  localparam int          RC   = 16;
  localparam logic [31:0] CID  = 32'hC41E_0001;
  localparam logic [31:0] BASE = 32'h3000_1000;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    int          ws;
    logic [4:0]  en;
    int          pre;
  } tx_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] cl_en;
  logic [NC-1:0] cl_rst;

  tx_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  mon_en   = 0;
  int  rst1_hi  = 0;
  int  other_hi = 0;

  chimera_cluster_ctrl_apb_if apb_if ();

  chimera_cluster_ctrl_apb #(
    .NumClusters (NC),
    .SettleCycles(SC),
    .RstCycles   (RC),
    .ChimeraId   (CID)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .apb             (apb_if),
    .cluster_clk_en_o(cl_en),
    .cluster_rst_o   (cl_rst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en != 0) begin
      if (cl_rst[1]) rst1_hi++;
      if ((cl_rst & 5'h1D) != 5'h00) other_hi++;
    end
  end

  function automatic tx_t mk(string name, logic wr, logic [11:0] off, logic [31:0] wdata,
                             logic [3:0] strb, logic [31:0] rdata, logic err, int ws,
                             logic [4:0] en, int pre);
    tx_t t;
    t.name = name; t.wr = wr; t.addr = BASE + {20'h0, off}; t.wdata = wdata; t.strb = strb;
    t.rdata = rdata; t.err = err; t.ws = ws; t.en = en; t.pre = pre;
    return t;
  endfunction

  task automatic apb_idle();
    apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
    apb_if.paddr_i = '0; apb_if.pwdata_i = '0; apb_if.pstrb_i = '0; apb_if.pprot_i = '0;
  endtask

  task automatic apb_drive(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rd, output logic er,
                           output int ws, output logic to, output logic [4:0] en_first);
    @(negedge clk);
    apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0; apb_if.pwrite_i = wr;
    apb_if.paddr_i = addr; apb_if.pwdata_i = wdata; apb_if.pstrb_i = strb; apb_if.pprot_i = 3'b010;
    @(negedge clk);
    apb_if.penable_i = 1'b1;
    ws = 0; to = 1'b0; en_first = 'x;
    #1;
    while (apb_if.pready_o !== 1'b1) begin
      if (ws >= 50) begin
        to = 1'b1;
        break;
      end
      @(negedge clk); #1;
      ws++;
      if (ws == 1) en_first = cl_en;
    end
    rd = apb_if.prdata_o;
    er = apb_if.pslverr_o;
    @(posedge clk); #1;
    if (ws == 0) en_first = cl_en;
    apb_idle();
  endtask

  task automatic test_reset();
    int hi = 0;
    logic [31:0] rd; logic er, to; int ws; logic [4:0] en; tx_t e;
    rst = 1'b1;
    apb_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b1; apb_if.paddr_i = BASE + 32'h00C;
    #1;
    n_checks++;
    if (apb_if.pready_o !== 1'b0 || apb_if.pslverr_o !== 1'b0 || apb_if.prdata_o !== 32'h0 ||
        cl_en !== 5'h00 || cl_rst !== 5'h1F) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b err=%b rdata=%h en=%h rst=%h, expected 0 0 00000000 00 1f",
               apb_if.pready_o, apb_if.pslverr_o, apb_if.prdata_o, cl_en, cl_rst);
    end
    @(negedge clk);
    apb_idle();
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (cl_rst === 5'h1F) hi++;
    end
    n_checks++;
    if (hi != RC) begin
      n_fail++;
      $display("FAIL reset_stretch: cluster reset high %0d cycles, expected %0d", hi, RC);
    end
    n_checks++;
    if (cl_rst !== 5'h00 || cl_en !== 5'h00) begin
      n_fail++;
      $display("FAIL reset_release: rst=%h en=%h, expected 00 00", cl_rst, cl_en);
    end
    exp_q.push_back(mk("id_read", 1'b0, 12'h00C, 32'h0, 4'hF, CID, 1'b0, 0, 5'h00, 0));
    apb_drive(1'b0, BASE + 32'h00C, 32'h0, 4'hF, rd, er, ws, to, en);
    e = exp_q.pop_front();
    n_checks++;
    if (to || er !== e.err || ws != e.ws || en !== e.en || rd !== e.rdata) begin
      n_fail++;
      $display("FAIL %s: rdata=%h err=%b ws=%0d en=%h timeout=%b, expected rdata=%h err=%b ws=%0d en=%h",
               e.name, rd, er, ws, en, to, e.rdata, e.err, e.ws, e.en);
    end
  endtask

  task automatic test_clk_en();
    tx_t t[$]; tx_t e;
    logic [31:0] rd; logic er, to; int ws; logic [4:0] en;
    t.push_back(mk("clk_en_write_15",   1'b1, 12'h000, 32'h15, 4'hF, 32'h0,  1'b0, SC, 5'h15, 0));
    t.push_back(mk("clk_en_rewrite_15", 1'b1, 12'h000, 32'h15, 4'hF, 32'h0,  1'b0, 0,  5'h15, 0));
    t.push_back(mk("clk_en_read",       1'b0, 12'h000, 32'h0,  4'hF, 32'h15, 1'b0, 0,  5'h15, 0));
    for (int i = 0; i < t.size(); i++) begin
      repeat (t[i].pre) @(posedge clk);
      exp_q.push_back(t[i]);
      apb_drive(t[i].wr, t[i].addr, t[i].wdata, t[i].strb, rd, er, ws, to, en);
      e = exp_q.pop_front();
      n_checks++;
      if (to || er !== e.err || ws != e.ws || en !== e.en || (!e.wr && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL %s: rdata=%h err=%b ws=%0d en=%h timeout=%b, expected rdata=%h err=%b ws=%0d en=%h",
                 e.name, rd, er, ws, en, to, e.rdata, e.err, e.ws, e.en);
      end
    end
  endtask

  task automatic test_strobe();
    tx_t t[$]; tx_t e;
    logic [31:0] rd; logic er, to; int ws; logic [4:0] en;
    t.push_back(mk("strb_none",      1'b1, 12'h000, 32'hFF,        4'b0000, 32'h0,  1'b0, 0,  5'h15, 0));
    t.push_back(mk("strb_upper",     1'b1, 12'h000, 32'hFFFF_FF00, 4'b1110, 32'h0,  1'b0, 0,  5'h15, 0));
    t.push_back(mk("strb_readback",  1'b0, 12'h000, 32'h0,         4'hF,    32'h15, 1'b0, 0,  5'h15, 0));
    t.push_back(mk("strb_lane0_0a",  1'b1, 12'h000, 32'hFFFF_FF0A, 4'b0001, 32'h0,  1'b0, SC, 5'h0A, 0));
    t.push_back(mk("strb_lane0_15",  1'b1, 12'h000, 32'hFFFF_FF15, 4'b0001, 32'h0,  1'b0, SC, 5'h15, 0));
    t.push_back(mk("strb_upper_rd0", 1'b0, 12'h000, 32'h0,         4'hF,    32'h15, 1'b0, 0,  5'h15, 0));
    for (int i = 0; i < t.size(); i++) begin
      repeat (t[i].pre) @(posedge clk);
      exp_q.push_back(t[i]);
      apb_drive(t[i].wr, t[i].addr, t[i].wdata, t[i].strb, rd, er, ws, to, en);
      e = exp_q.pop_front();
      n_checks++;
      if (to || er !== e.err || ws != e.ws || en !== e.en || (!e.wr && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL %s: rdata=%h err=%b ws=%0d en=%h timeout=%b, expected rdata=%h err=%b ws=%0d en=%h",
                 e.name, rd, er, ws, en, to, e.rdata, e.err, e.ws, e.en);
      end
    end
  endtask

  task automatic test_errors();
    tx_t t[$]; tx_t e;
    logic [31:0] rd; logic er, to; int ws; logic [4:0] en;
    t.push_back(mk("err_read_010",    1'b0, 12'h010, 32'h0,         4'hF, 32'h0,  1'b1, 0, 5'h15, 0));
    t.push_back(mk("err_write_status",1'b1, 12'h008, 32'hFFFF_FFFF, 4'hF, 32'h0,  1'b1, 0, 5'h15, 0));
    t.push_back(mk("err_write_id",    1'b1, 12'h00C, 32'h0,         4'hF, 32'h0,  1'b1, 0, 5'h15, 0));
    t.push_back(mk("err_read_002",    1'b0, 12'h002, 32'h0,         4'hF, 32'h0,  1'b1, 0, 5'h15, 0));
    t.push_back(mk("err_write_002",   1'b1, 12'h002, 32'h0,         4'hF, 32'h0,  1'b1, 0, 5'h15, 0));
    t.push_back(mk("err_write_006",   1'b1, 12'h006, 32'h1F,        4'hF, 32'h0,  1'b1, 0, 5'h15, 0));
    t.push_back(mk("soft_rst_read",   1'b0, 12'h004, 32'h0,         4'hF, 32'h0,  1'b0, 0, 5'h15, 0));
    t.push_back(mk("status_quiet",    1'b0, 12'h008, 32'h0,         4'hF, 32'h0,  1'b0, 0, 5'h15, 0));
    t.push_back(mk("clk_en_kept",     1'b0, 12'h000, 32'h0,         4'hF, 32'h15, 1'b0, 0, 5'h15, 0));
    t.push_back(mk("err_read_ffc",    1'b0, 12'hFFC, 32'h0,         4'hF, 32'h0,  1'b1, 0, 5'h15, 0));
    for (int i = 0; i < t.size(); i++) begin
      repeat (t[i].pre) @(posedge clk);
      exp_q.push_back(t[i]);
      apb_drive(t[i].wr, t[i].addr, t[i].wdata, t[i].strb, rd, er, ws, to, en);
      e = exp_q.pop_front();
      n_checks++;
      if (to || er !== e.err || ws != e.ws || en !== e.en || (!e.wr && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL %s: rdata=%h err=%b ws=%0d en=%h timeout=%b, expected rdata=%h err=%b ws=%0d en=%h",
                 e.name, rd, er, ws, en, to, e.rdata, e.err, e.ws, e.en);
      end
    end
  endtask

  task automatic test_soft_rst();
    tx_t t[$]; tx_t e;
    logic [31:0] rd; logic er, to; int ws; logic [4:0] en;
    t.push_back(mk("soft_rst_1",       1'b1, 12'h004, 32'h02, 4'hF,    32'h0,  1'b0, 0, 5'h15, 0));
    t.push_back(mk("soft_rst_again",   1'b1, 12'h004, 32'h02, 4'hF,    32'h0,  1'b0, 0, 5'h15, 8));
    t.push_back(mk("status_mid",       1'b0, 12'h008, 32'h0,  4'hF,    32'h02, 1'b0, 0, 5'h15, 0));
    t.push_back(mk("soft_rst_multi",   1'b1, 12'h004, 32'h19, 4'b0001, 32'h0,  1'b0, 0, 5'h15, 40));
    t.push_back(mk("status_multi",     1'b0, 12'h008, 32'h0,  4'hF,    32'h19, 1'b0, 0, 5'h15, 0));
    t.push_back(mk("soft_rst_no_strb", 1'b1, 12'h004, 32'h1F, 4'b0000, 32'h0,  1'b0, 0, 5'h15, 20));
    t.push_back(mk("status_after",     1'b0, 12'h008, 32'h0,  4'hF,    32'h0,  1'b0, 0, 5'h15, 0));
    rst1_hi = 0; other_hi = 0; mon_en = 1;
    for (int i = 0; i < t.size(); i++) begin
      if (i == 3) begin
        repeat (t[i].pre) @(posedge clk);
        mon_en = 0;
        n_checks++;
        if (rst1_hi != 10 + RC || other_hi != 0) begin
          n_fail++;
          $display("FAIL soft_rst_restart: cluster1 high %0d cycles, others %0d, expected %0d and 0",
                   rst1_hi, other_hi, 10 + RC);
        end
      end else begin
        repeat (t[i].pre) @(posedge clk);
      end
      exp_q.push_back(t[i]);
      apb_drive(t[i].wr, t[i].addr, t[i].wdata, t[i].strb, rd, er, ws, to, en);
      e = exp_q.pop_front();
      n_checks++;
      if (to || er !== e.err || ws != e.ws || en !== e.en || (!e.wr && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL %s: rdata=%h err=%b ws=%0d en=%h timeout=%b, expected rdata=%h err=%b ws=%0d en=%h",
                 e.name, rd, er, ws, en, to, e.rdata, e.err, e.ws, e.en);
      end
    end
  endtask

  task automatic test_reset_in_settle();
    tx_t t[$]; tx_t e;
    logic [31:0] rd; logic er, to; int ws; logic [4:0] en;
    @(negedge clk);
    apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b1;
    apb_if.paddr_i = BASE; apb_if.pwdata_i = 32'h1F; apb_if.pstrb_i = 4'hF;
    @(negedge clk);
    apb_if.penable_i = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (cl_en !== 5'h1F || apb_if.pready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_entry: en=%h ready=%b, expected 1f 0", cl_en, apb_if.pready_o);
    end
    rst = 1'b1;
    apb_idle();
    @(posedge clk); #1;
    n_checks++;
    if (cl_en !== 5'h00 || apb_if.pready_o !== 1'b0 || cl_rst !== 5'h1F ||
        apb_if.pslverr_o !== 1'b0 || apb_if.prdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL settle_reset: en=%h ready=%b rst=%h err=%b rdata=%h, expected 00 0 1f 0 00000000",
               cl_en, apb_if.pready_o, cl_rst, apb_if.pslverr_o, apb_if.prdata_o);
    end
    @(negedge clk);
    rst = 1'b0;
    t.push_back(mk("post_rst_write_0a", 1'b1, 12'h000, 32'h0A, 4'hF, 32'h0,  1'b0, SC, 5'h0A, 20));
    t.push_back(mk("post_rst_status",   1'b0, 12'h008, 32'h0,  4'hF, 32'h0,  1'b0, 0,  5'h0A, 0));
    t.push_back(mk("post_rst_read",     1'b0, 12'h000, 32'h0,  4'hF, 32'h0A, 1'b0, 0,  5'h0A, 0));
    for (int i = 0; i < t.size(); i++) begin
      repeat (t[i].pre) @(posedge clk);
      exp_q.push_back(t[i]);
      apb_drive(t[i].wr, t[i].addr, t[i].wdata, t[i].strb, rd, er, ws, to, en);
      e = exp_q.pop_front();
      n_checks++;
      if (to || er !== e.err || ws != e.ws || en !== e.en || (!e.wr && rd !== e.rdata)) begin
        n_fail++;
        $display("FAIL %s: rdata=%h err=%b ws=%0d en=%h timeout=%b, expected rdata=%h err=%b ws=%0d en=%h",
                 e.name, rd, er, ws, en, to, e.rdata, e.err, e.ws, e.en);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    apb_idle();
    test_reset();
    test_clk_en();
    test_strobe();
    test_errors();
    test_soft_rst();
    test_reset_in_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
